// File: rtl/led_matrix_pkg.sv
// Shared constants and types for the LED matrix datapath.
//   - RGB565 field positions within a framebuffer word
//   - default scan geometry (16 scan rows x 64 columns)
//   - bitplane mask width and the buffer-swap FSM state encoding
package led_matrix_pkg;

  localparam int unsigned DEF_ROW_BITS    = 4;
  localparam int unsigned DEF_COL_BITS    = 6;
  localparam int unsigned DEF_PIXEL_WIDTH = 16;

  localparam int unsigned MASK_WIDTH = 6;
  localparam int unsigned RGB_WIDTH  = 3;

  // RGB565 layout: rrrrr_gggggg_bbbbb
  localparam int unsigned R_MSB = 15;
  localparam int unsigned R_LSB = 11;
  localparam int unsigned G_MSB = 10;
  localparam int unsigned G_LSB = 5;
  localparam int unsigned B_MSB = 4;
  localparam int unsigned B_LSB = 0;

  // One shift-register bit per colour for a half row.
  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_bits_t;

  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_e;

  // Widen a 5-bit channel to 6 bits by replicating its MSB into the LSB,
  // so full scale (11111) maps to full scale (111111).
  function automatic logic [MASK_WIDTH-1:0] expand5(input logic [4:0] c5);
    return {c5, c5[4]};
  endfunction

endpackage

// File: rtl/framebuffer_fetch_if.sv
// Framebuffer RAM read bus: one read strobe shared by two synchronous-read
// ports (top half row / bottom half row).
//   master : fetch stage (drives strobe and addresses, receives data)
//   slave  : RAM (receives strobe and addresses, returns data one cycle later)
interface framebuffer_fetch_if #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned PIXEL_WIDTH = 16
);

  logic                   ram_rd_en;
  logic [ADDR_W-1:0]      ram_addr_top;
  logic [ADDR_W-1:0]      ram_addr_bottom;
  logic [PIXEL_WIDTH-1:0] ram_data_top;
  logic [PIXEL_WIDTH-1:0] ram_data_bottom;

  modport master (
    output ram_rd_en,
    output ram_addr_top,
    output ram_addr_bottom,
    input  ram_data_top,
    input  ram_data_bottom
  );

  modport slave (
    input  ram_rd_en,
    input  ram_addr_top,
    input  ram_addr_bottom,
    output ram_data_top,
    output ram_data_bottom
  );

endinterface

// File: rtl/rgb565_bitplane_slice.sv
// Combinational bitplane extraction from one RGB565 pixel.
//   pixel : RGB565 framebuffer word
//   mask  : one-hot bitplane select (all-zero blanks the pixel)
//   rgb_c : {r,g,b} bit of the selected plane
module rgb565_bitplane_slice
  import led_matrix_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = DEF_PIXEL_WIDTH
) (
  input  logic [PIXEL_WIDTH-1:0] pixel,
  input  logic [MASK_WIDTH-1:0]  mask,
  output rgb_bits_t              rgb_c
);

  logic [MASK_WIDTH-1:0] r6_c;
  logic [MASK_WIDTH-1:0] g6_c;
  logic [MASK_WIDTH-1:0] b6_c;

  // Bring every channel to 6 bits, then pick the masked plane by OR-reduction.
  always_comb begin
    r6_c    = expand5(pixel[R_MSB:R_LSB]);
    g6_c    = pixel[G_MSB:G_LSB];
    b6_c    = expand5(pixel[B_MSB:B_LSB]);
    rgb_c.r = |(r6_c & mask);
    rgb_c.g = |(g6_c & mask);
    rgb_c.b = |(b6_c & mask);
  end

endmodule

// File: rtl/framebuffer_fetch.sv
// Pixel fetch stage feeding the panel scan block.
// Reads the top/bottom pixel of the current column during load bursts,
// slices the active brightness bitplane and presents registered RGB bits
// two clk_in cycles after the load strobe.
//
// Build option: DOUBLE_BUFFER_EN
//   defined   - two framebuffers, swap_request is honoured at frame boundaries
//   undefined - single buffer, frame_sel/swap_ack tied low, swap_request ignored
//
// Ports:
//   clk_in, reset_n        clock, asynchronous active-low reset
//   pixel_load_en          load-burst enable from the scan block
//   column_address         current column
//   row_address            current scan row
//   brightness_mask        one-hot bitplane select, 0 = blank
//   ram                    framebuffer read bus (master side)
//   rgb_top, rgb_bottom    {r,g,b} bits for the upper / lower half row
//   pixel_valid            rgb_* carry a fetched pixel this cycle
//   swap_request           single-cycle buffer-swap request
//   swap_ack               one-cycle pulse on the first cycle of a new frame_sel
//   frame_sel              buffer currently displayed
module framebuffer_fetch
  import led_matrix_pkg::*;
#(
  parameter int unsigned ROW_BITS    = DEF_ROW_BITS,
  parameter int unsigned COL_BITS    = DEF_COL_BITS,
  parameter int unsigned PIXEL_WIDTH = DEF_PIXEL_WIDTH
) (
  input  logic                  clk_in,
  input  logic                  reset_n,
  input  logic                  pixel_load_en,
  input  logic [COL_BITS-1:0]   column_address,
  input  logic [ROW_BITS-1:0]   row_address,
  input  logic [MASK_WIDTH-1:0] brightness_mask,
  framebuffer_fetch_if.master   ram,
  output logic [RGB_WIDTH-1:0]  rgb_top,
  output logic [RGB_WIDTH-1:0]  rgb_bottom,
  output logic                  pixel_valid,
  input  logic                  swap_request,
  output logic                  swap_ack,
  output logic                  frame_sel
);

  // Stage 0: addresses come straight from the live scan position.
  assign ram.ram_rd_en       = pixel_load_en;
  assign ram.ram_addr_top    = {frame_sel, 1'b0, row_address, column_address};
  assign ram.ram_addr_bottom = {frame_sel, 1'b1, row_address, column_address};

  // Stage 1: align mask and valid with the RAM read latency.
  logic                  v1;
  logic [MASK_WIDTH-1:0] mask_s1;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      v1      <= 1'b0;
      mask_s1 <= '0;
    end else begin
      v1      <= pixel_load_en;
      mask_s1 <= brightness_mask;
    end
  end

  rgb_bits_t top_bits_c;
  rgb_bits_t bottom_bits_c;

  rgb565_bitplane_slice #(.PIXEL_WIDTH(PIXEL_WIDTH)) u_slice_top (
    .pixel (ram.ram_data_top),
    .mask  (mask_s1),
    .rgb_c (top_bits_c)
  );

  rgb565_bitplane_slice #(.PIXEL_WIDTH(PIXEL_WIDTH)) u_slice_bottom (
    .pixel (ram.ram_data_bottom),
    .mask  (mask_s1),
    .rgb_c (bottom_bits_c)
  );

  // Stage 2: registered outputs; RAM data is meaningless when v1 is low.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      rgb_top     <= '0;
      rgb_bottom  <= '0;
      pixel_valid <= 1'b0;
    end else begin
      pixel_valid <= v1;
      rgb_top     <= v1 ? RGB_WIDTH'(top_bits_c)    : '0;
      rgb_bottom  <= v1 ? RGB_WIDTH'(bottom_bits_c) : '0;
    end
  end

`ifdef DOUBLE_BUFFER_EN

  logic [ROW_BITS-1:0] row_prev;
  swap_state_e         swap_state;
  logic                defer;
  logic                frame_start_c;
  logic                pipe_idle_c;

  // Frame boundary: last scan row wraps back to row 0.
  assign frame_start_c = (row_prev == {ROW_BITS{1'b1}}) && (row_address == '0);
  // Safe to swap only when nothing is in flight or being issued.
  assign pipe_idle_c   = !pixel_load_en && !v1 && !pixel_valid;

  // Swap FSM; a boundary hit during traffic is remembered in defer and the
  // swap is taken on the first idle cycle afterwards.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      row_prev   <= '0;
      swap_state <= SWAP_IDLE;
      defer      <= 1'b0;
      frame_sel  <= 1'b0;
      swap_ack   <= 1'b0;
    end else begin
      row_prev <= row_address;
      swap_ack <= 1'b0;
      case (swap_state)
        SWAP_IDLE: begin
          defer <= 1'b0;
          if (swap_request) begin
            swap_state <= SWAP_PENDING;
          end
        end
        SWAP_PENDING: begin
          // Further requests here are absorbed: no queueing.
          if ((frame_start_c || defer) && pipe_idle_c) begin
            frame_sel  <= ~frame_sel;
            swap_ack   <= 1'b1;
            defer      <= 1'b0;
            swap_state <= SWAP_IDLE;
          end else if (frame_start_c) begin
            defer <= 1'b1;
          end
        end
      endcase
    end
  end

`else

  // Single buffer: no swap machinery.
  logic unused_swap_request;

  assign unused_swap_request = swap_request;
  assign frame_sel           = 1'b0;
  assign swap_ack            = 1'b0;

`endif

endmodule

// File: tb/tb_framebuffer_fetch.sv
// Scoreboard bench for framebuffer_fetch: a driver issues load bursts and
// swap traffic while a monitor compares every output cycle against a queue
// of expected pixels produced by a behavioural model and a RAM array.
module tb_framebuffer_fetch;

`ifdef DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic       clk_in = 1'b0;
  logic       reset_n = 1'b0;
  logic       pixel_load_en = 1'b0;
  logic       swap_request = 1'b0;
  logic [5:0] column_address = '0;
  logic [3:0] row_address = '0;
  logic [5:0] brightness_mask = '0;
  logic [2:0] rgb_top;
  logic [2:0] rgb_bottom;
  logic       pixel_valid;
  logic       swap_ack;
  logic       frame_sel;

  always #5 clk_in = ~clk_in;

  framebuffer_fetch_if #(.ADDR_W(12), .PIXEL_WIDTH(16)) ram_if ();

  framebuffer_fetch dut (
    .clk_in          (clk_in),
    .reset_n         (reset_n),
    .pixel_load_en   (pixel_load_en),
    .column_address  (column_address),
    .row_address     (row_address),
    .brightness_mask (brightness_mask),
    .ram             (ram_if),
    .rgb_top         (rgb_top),
    .rgb_bottom      (rgb_bottom),
    .pixel_valid     (pixel_valid),
    .swap_request    (swap_request),
    .swap_ack        (swap_ack),
    .frame_sel       (frame_sel)
  );

  // Framebuffer RAM model: synchronous read on both ports.
  logic [15:0] mem [0:4095];
  logic [15:0] dt = '0;
  logic [15:0] db = '0;
  always @(posedge clk_in) begin
    if (ram_if.ram_rd_en) begin
      dt <= mem[ram_if.ram_addr_top];
      db <= mem[ram_if.ram_addr_bottom];
    end
  end
  assign ram_if.ram_data_top    = dt;
  assign ram_if.ram_data_bottom = db;

  int unsigned cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int unsigned ack_count = 0;
  logic exp_fs = 1'b0;

  typedef struct {
    logic [2:0]  top;
    logic [2:0]  bot;
    int unsigned cyc;
  } exp_t;
  exp_t exp_q[$];

  function automatic void check(input string name, input int unsigned act, input int unsigned req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Reference: widen each channel to 6 bits, then the pixel bit for a
  // channel is set if any selected plane of that channel is set.
  function automatic logic model_bit(input int unsigned ch6, input logic [5:0] mask);
    logic b;
    b = 1'b0;
    for (int k = 0; k < 6; k++)
      if (mask[k] && ((ch6 >> k) % 2) == 1) b = 1'b1;
    return b;
  endfunction

  function automatic logic [2:0] model_rgb(input logic [15:0] px, input logic [5:0] mask);
    int unsigned r5, g6, b5;
    r5 = 32'(px[15:11]);
    g6 = 32'(px[10:5]);
    b5 = 32'(px[4:0]);
    return {model_bit(r5 * 2 + r5 / 16, mask),
            model_bit(g6, mask),
            model_bit(b5 * 2 + b5 / 16, mask)};
  endfunction

  // Monitor: every cycle, pop on pixel_valid, else require blank RGB;
  // frame_sel may only move together with swap_ack and outside valid data.
  logic prev_fs = 1'b0;
  always @(negedge clk_in) begin
    exp_t e;
    if (!reset_n) begin
      prev_fs = frame_sel;
    end else begin
      if (pixel_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_valid: got pixel_valid=1, expected 0 (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("latency", cyc, e.cyc);
          check("rgb_top", 32'(rgb_top), 32'(e.top));
          check("rgb_bottom", 32'(rgb_bottom), 32'(e.bot));
        end
      end else begin
        check("idle_rgb", 32'({rgb_top, rgb_bottom}), 0);
      end
      if (frame_sel !== prev_fs) begin
        check("fs_change_ack", 32'(swap_ack), 1);
        check("fs_change_valid", 32'(pixel_valid), 0);
      end else if (swap_ack) begin
        tests++;
        fails++;
        $display("FAIL ack_no_change: got swap_ack=1 with frame_sel unchanged, expected 0 (t=%0t)", $time);
      end
      if (swap_ack) ack_count++;
      prev_fs = frame_sel;
    end
  end

  task automatic load_cycle(input logic [3:0] row, input logic [5:0] col, input logic [5:0] mask);
    int unsigned a_top, a_bot;
    exp_t e;
    a_top = 32'(exp_fs) * 2048 + 32'(row) * 64 + 32'(col);
    a_bot = a_top + 1024;
    row_address     = row;
    column_address  = col;
    brightness_mask = mask;
    pixel_load_en   = 1'b1;
    e.top = model_rgb(mem[a_top], mask);
    e.bot = model_rgb(mem[a_bot], mask);
    e.cyc = cyc + 2;
    exp_q.push_back(e);
    @(negedge clk_in);
    check("addr_top", 32'(ram_if.ram_addr_top), a_top);
    check("addr_bottom", 32'(ram_if.ram_addr_bottom), a_bot);
    check("rd_en_load", 32'(ram_if.ram_rd_en), 1);
    @(posedge clk_in); #1;
  endtask

  task automatic idle(input int n);
    pixel_load_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      check("rd_en_idle", 32'(ram_if.ram_rd_en), 0);
      @(posedge clk_in); #1;
    end
  endtask

  task automatic burst(input logic [3:0] row, input int start_col, input int len, input logic [5:0] mask);
    for (int i = 0; i < len; i++) load_cycle(row, 6'(start_col + i), mask);
  endtask

  task automatic fill_row(input logic [3:0] row, input logic [15:0] top, input logic [15:0] bot);
    for (int c = 0; c < 64; c++) begin
      mem[32'(row) * 64 + c]        = top;
      mem[1024 + 32'(row) * 64 + c] = bot;
    end
  endtask

  function automatic logic [5:0] rand_mask();
    int unsigned k;
    k = $urandom_range(0, 6);
    return (k == 6) ? 6'b000000 : 6'(1 << k);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);

    // Reset values and combinational read strobe.
    pixel_load_en = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_rd_en_follow_hi", 32'(ram_if.ram_rd_en), 1);
    pixel_load_en = 1'b0;
    #1;
    check("rst_rd_en_follow_lo", 32'(ram_if.ram_rd_en), 0);
    check("rst_pixel_valid", 32'(pixel_valid), 0);
    check("rst_rgb", 32'({rgb_top, rgb_bottom}), 0);
    check("rst_swap_ack", 32'(swap_ack), 0);
    check("rst_frame_sel", 32'(frame_sel), 0);
    reset_n = 1'b1;
    @(posedge clk_in); #1;
    idle(2);

    // Pure red top, pure green bottom, MSB plane.
    fill_row(4'd3, 16'hF800, 16'h07E0);
    burst(4'd3, 0, 64, 6'b100000);
    idle(3);

    // Blue MSB replicated into LSB plane.
    fill_row(4'd4, 16'h0010, 16'h001F);
    burst(4'd4, 0, 64, 6'b000001);
    idle(2);
    burst(4'd4, 0, 64, 6'b100000);
    idle(3);

    // Blank mask still produces valid cycles.
    burst(4'd5, 0, 64, 6'b000000);
    idle(3);

    // Random bursts over random rows, columns, planes and gaps.
    for (int b = 0; b < 24; b++) begin
      burst(4'($urandom_range(0, 14)), int'($urandom_range(0, 63)),
            int'($urandom_range(1, 64)), rand_mask());
      idle(int'($urandom_range(0, 3)));
    end
    idle(3);

    // Swap requested mid-frame waits for the 15 -> 0 boundary; repeat absorbed.
    row_address = 4'd7;
    idle(2);
    swap_request = 1'b1;
    idle(1);
    swap_request = 1'b0;
    idle(2);
    row_address = 4'd9;
    swap_request = 1'b1;
    idle(1);
    swap_request = 1'b0;
    check("fs_before_boundary", 32'(frame_sel), 32'(exp_fs));
    burst(4'd15, 0, 8, rand_mask());
    idle(3);
    check("fs_at_row15", 32'(frame_sel), 32'(exp_fs));
    row_address = 4'd0;
    idle(1);
    exp_fs = exp_fs ^ DB;
    check("fs_after_boundary", 32'(frame_sel), 32'(exp_fs));
    check("ack_at_swap", 32'(swap_ack), 32'(DB));
    idle(1);
    check("ack_one_cycle", 32'(swap_ack), 0);
    burst(4'd0, 0, 8, rand_mask());
    idle(3);

    // Boundary during a burst: swap deferred until the pipeline drains.
    row_address = 4'd14;
    idle(1);
    swap_request = 1'b1;
    idle(1);
    swap_request = 1'b0;
    burst(4'd15, 56, 8, rand_mask());
    burst(4'd0, 0, 8, rand_mask());
    idle(1);
    check("defer_fs_1", 32'(frame_sel), 32'(exp_fs));
    idle(1);
    check("defer_fs_2", 32'(frame_sel), 32'(exp_fs));
    idle(1);
    exp_fs = exp_fs ^ DB;
    check("defer_fs_swapped", 32'(frame_sel), 32'(exp_fs));
    check("defer_ack", 32'(swap_ack), 32'(DB));
    // Request on the ack cycle re-arms for the next frame.
    swap_request = 1'b1;
    idle(1);
    swap_request = 1'b0;
    check("rearm_ack_low", 32'(swap_ack), 0);
    row_address = 4'd15;
    idle(2);
    row_address = 4'd0;
    idle(1);
    exp_fs = exp_fs ^ DB;
    check("rearm_fs", 32'(frame_sel), 32'(exp_fs));
    check("rearm_ack", 32'(swap_ack), 32'(DB));
    idle(2);

    // Reset in the middle of a burst.
    burst(4'd2, 0, 30, rand_mask());
    column_address = 6'd30;
    pixel_load_en  = 1'b1;
    reset_n        = 1'b0;
    exp_q.delete();
    exp_fs = 1'b0;
    #1;
    check("midrst_valid", 32'(pixel_valid), 0);
    check("midrst_rgb", 32'({rgb_top, rgb_bottom}), 0);
    check("midrst_fs", 32'(frame_sel), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_in); #1;
      check("rst_hold_valid", 32'(pixel_valid), 0);
    end
    reset_n       = 1'b1;
    pixel_load_en = 1'b0;
    idle(5);
    check("post_rst_fs", 32'(frame_sel), 0);
    burst(4'd2, 0, 64, rand_mask());
    idle(6);

    check("queue_drained", 32'(exp_q.size()), 0);
    check("ack_count", ack_count, 3 * 32'(DB));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/framebuffer_fetch.md
# framebuffer_fetch

Pixel fetch stage sitting directly upstream of the panel scan block. During each 64-pixel load burst it reads the top-half and bottom-half pixels for the current column from the framebuffer RAM. It slices the bit selected by the scan block's current brightness mask out of each colour channel and presents registered `rgb_top`/`rgb_bottom` bits to the panel shift-register drivers. Optionally it double-buffers the framebuffer, with swaps taken only at frame boundaries.

## Interface
Parameters:
- `ROW_BITS`, 4, row address width (16 scan rows; 32 physical rows).
- `COL_BITS`, 6, column address width (64 columns).
- `PIXEL_WIDTH`, 16, RAM word width, RGB565.

Ports:
- `clk_in`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pixel_load_en`  in  1  load-burst enable from scan block (`clk_pixel_load_en2`).
- `column_address`  in  COL_BITS  current column from scan block.
- `row_address`  in  ROW_BITS  current row being loaded.
- `brightness_mask`  in  6  one-hot bitplane select; 0 means blank.
- `ram_rd_en`  out  1  read strobe to both RAM ports.
- `ram_addr_top`  out  ROW_BITS+COL_BITS+2  `{frame_sel, 1'b0, row, col}`.
- `ram_addr_bottom`  out  ROW_BITS+COL_BITS+2  `{frame_sel, 1'b1, row, col}`.
- `ram_data_top`  in  PIXEL_WIDTH  synchronous-read data, valid 1 cycle after `ram_rd_en`.
- `ram_data_bottom`  in  PIXEL_WIDTH  synchronous-read data, same timing.
- `rgb_top`  out  3  `{r,g,b}` bit for the upper half row.
- `rgb_bottom`  out  3  `{r,g,b}` bit for the lower half row.
- `pixel_valid`  out  1  `rgb_*` hold a fetched pixel this cycle.
- `swap_request`  in  1  single-cycle pulse requesting a buffer swap.
- `swap_ack`  out  1  one-cycle pulse when the swap is applied.
- `frame_sel`  out  1  buffer currently displayed.

## Operation
- Stage 0 (combinational): `ram_rd_en = pixel_load_en`. Addresses are formed from the live `row_address`, `column_address` and `frame_sel`.
- Stage 1 (register): capture `brightness_mask` and `v1 = pixel_load_en`.
- Stage 2 (register):
  - Expand RGB565 to 6 bits per channel: `R = {r5, r5[4]}`, `G = g6`, `B = {b5, b5[4]}`.
  - Each output bit is the OR-reduction of `channel & mask_s1`.
  - `pixel_valid <= v1`.
  - When `v1 = 0`, `rgb_*` are forced to `3'b000`.
- Mask `0` (post-reset value of the scan block) yields all-zero RGB with `pixel_valid` still following `v1`.
- Frame-boundary detection:
  - `row_prev` register samples `row_address` every cycle.
  - `frame_start` is asserted when `row_prev == 2^ROW_BITS-1` and `row_address == 0`.
- Swap FSM, states `IDLE`, `PENDING`:
  - `IDLE` goes to `PENDING` on `swap_request`.
  - In `PENDING`, a swap is taken on `frame_start` when `pixel_load_en = 0` and the pipeline is empty (`v1 = 0`, `pixel_valid = 0`). The swap toggles `frame_sel`, pulses `swap_ack`, and returns to `IDLE`.
  - A `frame_start` that coincides with an active load or non-empty pipeline sets a `defer` flag. The swap then occurs on the first cycle with `pixel_load_en = 0` and the pipeline empty.
  - `swap_request` arriving while in `PENDING` is absorbed; there is no queueing and no second ack.
  - `swap_request` arriving on the same cycle as `swap_ack` re-arms `PENDING`.

## Timing
- Latency from `pixel_load_en`/address sample to `rgb_*`/`pixel_valid`: exactly 2 `clk_in` cycles. A burst of N load cycles produces exactly N consecutive `pixel_valid` cycles.
- `frame_sel` changes only between bursts and never inside the two-cycle pipeline window.
- `swap_ack` is high for exactly one cycle, coincident with the first cycle of the new `frame_sel`.
- Reset values: `rgb_top = rgb_bottom = 0`, `pixel_valid = 0`, `swap_ack = 0`, `frame_sel = 0`, `row_prev = 0`, FSM = `IDLE`, pipeline valids = 0. `ram_rd_en` follows `pixel_load_en` combinationally.
- Reset asserted mid-burst clears the pipeline immediately. No residual `pixel_valid` appears after release.

## Configuration
- `DOUBLE_BUFFER_EN` defined: full swap FSM; `frame_sel` drives the address MSB.
- Undefined:
  - `frame_sel` is tied to 0 and `swap_ack` to 0.
  - `swap_request` is ignored.
  - Address MSB is constant 0.
  - Swap FSM and `row_prev` are not built.
  - Fetch pipeline behaviour is identical.

## Structure
- Shared package, `led_matrix_pkg`:
  - RGB565 field positions (`R_MSB`/`R_LSB` etc.).
  - Default `ROW_BITS`/`COL_BITS`.
  - `MASK_WIDTH = 6`.
  - Swap FSM state encoding.
- One sub-module, `rgb565_bitplane_slice`: combinational expansion plus mask reduction, instantiated twice (top and bottom).
- Pipeline registers and swap FSM live in `framebuffer_fetch`.

## Test plan
- Reset, then burst of 64 load cycles with `row = 3`, mask `6'b100000`; RAM top = `16'hF800`, bottom = `16'h07E0` → `rgb_top = 3'b100` and `rgb_bottom = 3'b010` for 64 cycles, starting exactly 2 cycles after the first load.
- Top = `16'h0010` (`b5 = 10000`) with mask `000001`, then mask `100000` → `rgb_top` b bit = 1 in both bursts (MSB replicates into LSB).
- Mask = 0 during a burst → `pixel_valid` high for 64 cycles, `rgb_* = 000` throughout.
- `DOUBLE_BUFFER_EN`: pulse `swap_request` at row 7 → `frame_sel` unchanged until the row 15→0 transition. Then `swap_ack` pulses once and `ram_addr_top` MSB = 1 on the next burst.
- `DOUBLE_BUFFER_EN`: hold `pixel_load_en` high across the 15→0 row change with a swap pending → swap deferred until 2 cycles after `pixel_load_en` falls. There must be no `frame_sel` change while `pixel_valid` is high.
- Assert `reset_n` low at column 30 of a burst → `pixel_valid`, `rgb_*` and `frame_sel` are 0 immediately, and remain 0 after release until a new burst begins.
